// File: rtl/ultra_ram_tdp_be.sv
// True dual-port RAM with per-lane byte writes, per-port write modes and a
// valid-qualified output pipeline. Also flags and counts same-address collisions.
module ultra_ram_tdp_be #(
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 72,
  parameter int BWIDTH = 9,
  parameter int NBPIPE = 3,
  parameter int MODE_A = 0,
  parameter int MODE_B = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic                       enb,
  input  logic [DWIDTH/BWIDTH-1:0]   wea,
  input  logic [DWIDTH/BWIDTH-1:0]   web,
  input  logic [DWIDTH-1:0]          dina,
  input  logic [DWIDTH-1:0]          dinb,
  input  logic [AWIDTH-1:0]          addra,
  input  logic [AWIDTH-1:0]          addrb,
  output logic [DWIDTH-1:0]          douta,
  output logic [DWIDTH-1:0]          doutb,
  output logic                       douta_vld,
  output logic                       doutb_vld,
  output logic                       coll,
  output logic [15:0]                coll_cnt
);

  localparam int NBYTE = DWIDTH / BWIDTH;
  localparam int DEPTH = 1 << AWIDTH;

  logic [DWIDTH-1:0] r_mem [DEPTH];

  logic              w_wr_a, w_wr_b;
  logic [DWIDTH-1:0] w_old_a, w_old_b;
  logic [DWIDTH-1:0] w_mrg_a, w_mrg_b;
  logic [DWIDTH-1:0] w_word_a, w_word_b;
  logic              w_ld_a, w_ld_b;
  logic              w_coll;

  assign w_wr_a  = |wea;
  assign w_wr_b  = |web;
  assign w_old_a = r_mem[addra];
  assign w_old_b = r_mem[addrb];

  always_comb begin
    w_mrg_a = w_old_a;
    w_mrg_b = w_old_b;
    for (int l = 0; l < NBYTE; l++) begin
      if (wea[l]) w_mrg_a[l*BWIDTH +: BWIDTH] = dina[l*BWIDTH +: BWIDTH];
      if (web[l]) w_mrg_b[l*BWIDTH +: BWIDTH] = dinb[l*BWIDTH +: BWIDTH];
    end
  end

  // Write-first returns the port's own merged word; every other case returns pre-write data.
  assign w_word_a = (w_wr_a && MODE_A == 2) ? w_mrg_a : w_old_a;
  assign w_word_b = (w_wr_b && MODE_B == 2) ? w_mrg_b : w_old_b;
  assign w_ld_a   = ena && (!w_wr_a || MODE_A != 0);
  assign w_ld_b   = enb && (!w_wr_b || MODE_B != 0);
  assign w_coll   = ena && enb && (addra == addrb) && (w_wr_a || w_wr_b);

  // Array is never reset; port B lane writes land last so B wins on a shared lane.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int l = 0; l < NBYTE; l++) begin
        if (ena && wea[l]) r_mem[addra][l*BWIDTH +: BWIDTH] <= dina[l*BWIDTH +: BWIDTH];
        if (enb && web[l]) r_mem[addrb][l*BWIDTH +: BWIDTH] <= dinb[l*BWIDTH +: BWIDTH];
      end
    end
  end

  logic [DWIDTH-1:0] r_pa [NBPIPE+1];
  logic [DWIDTH-1:0] r_pb [NBPIPE+1];
  logic [NBPIPE:0]   r_va, r_vb;
  logic              r_coll;
  logic [15:0]       r_coll_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_va <= '0;
      r_vb <= '0;
      for (int k = 0; k <= NBPIPE; k++) begin
        r_pa[k] <= '0;
        r_pb[k] <= '0;
      end
    end else begin
      r_va <= {r_va[NBPIPE-1:0], w_ld_a};
      r_vb <= {r_vb[NBPIPE-1:0], w_ld_b};
      if (w_ld_a) r_pa[0] <= w_word_a;
      if (w_ld_b) r_pb[0] <= w_word_b;
      for (int k = 1; k <= NBPIPE; k++) begin
        if (r_va[k-1]) r_pa[k] <= r_pa[k-1];
        if (r_vb[k-1]) r_pb[k] <= r_pb[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_coll     <= 1'b0;
      r_coll_cnt <= '0;
    end else begin
      r_coll <= w_coll;
      if (w_coll && r_coll_cnt != 16'hFFFF) r_coll_cnt <= r_coll_cnt + 16'd1;
    end
  end

  assign douta     = r_pa[NBPIPE];
  assign doutb     = r_pb[NBPIPE];
  assign douta_vld = r_va[NBPIPE];
  assign doutb_vld = r_vb[NBPIPE];
  assign coll      = r_coll;
  assign coll_cnt  = r_coll_cnt;

endmodule
